display_mode_ctrl: RTL and testbench
====================================

// Module: display_mode_ctrl
// PURPOSE
//   Sequential mode controller for the switch-to-seven-segment display path.
//   - Debounces three active-low push buttons and turns each release-to-press edge into a mode select.
//   - Holds the selected display mode (HEX / BCD / DEC) in an FSM.
//   - Drives registered Hex_7 mode glyph, Hex_1 tens glyph and Hex_0 units nibble from the 4-bit switch value.
//   - Sits between board I/O and the hex/bcd seven-segment decoders.
// PARAMETERS
//   DB_CYCLES   500000    consecutive stable samples before a button change is accepted (10 ms @ 50 MHz)
//   DB_W        20        debounce counter width; must hold DB_CYCLES
//   AUTO_PERIOD 50000000  cycles per auto-advance step (used only with AUTO_CYCLE_EN)
// PORTS
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   enable    in   1  display enable; low forces OFF
//   PB        in   3  push buttons, active-low, asynchronous to clk
//   SW        in   4  switch value to display
//   mode      out  2  current state: 0=OFF 1=HEX 2=BCD 3=DEC
//   Hex_7     out  7  mode glyph, active-low segments
//   Hex_1     out  7  tens glyph, active-low segments
//   Hex_0     out  4  units value, fed to the digit decoder
//   digit_on  out  1  high when Hex_0 is to be displayed (0 in OFF)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - state=OFF; Hex_7=Hex_1=7'b1111111; Hex_0=0; digit_on=0.
//   - Synchronisers and debounced button state are set to 3'b111 (released); all counters are set to 0.
//   Synchronisation: each PB bit goes through a 2-flop synchroniser.
//   Debounce (per bit):
//   - The counter increments while the synchronised value differs from the debounced value.
//   - The counter clears when the two values match.
//   - When the count reaches DB_CYCLES-1 the debounced value flips and the counter clears.
//   Press event: a debounced 1->0 transition, pulsed for 1 cycle.
//   Event decode:
//   - PB[0] -> HEX, PB[1] -> BCD, PB[2] -> DEC.
//   - Same-cycle events resolve by priority PB[0] > PB[1] > PB[2].
//   - Pressing the button of the current mode is a no-op.
//   FSM:
//   - OFF -> selected mode on an event when enable=1.
//   - Any state -> OFF in the next cycle when enable=0; events are ignored while enable=0.
//   - enable rising leaves the FSM in OFF until the next event.
//   Output latency:
//   - Outputs are registered from the current state and SW, so a state or SW change appears 1 cycle later.
//   - Press-to-display: 2 (sync) + DB_CYCLES + 1 (FSM) + 1 (output) cycles.
//   Hex_7 glyph: OFF 1111111, HEX 0001011, BCD 0000011, DEC 0100001.
//   HEX: Hex_0=SW; Hex_1=1111111.
//   BCD: Hex_0 = SW if SW<10, else 9 (saturate); Hex_1=1111111.
//   DEC:
//   - SW<10: Hex_0=SW; Hex_1=1111111.
//   - SW>=10: Hex_0=SW-10 as a 4-bit result; Hex_1=1111001 ("1").
//   OFF: Hex_0=0; digit_on=0; both glyphs blank.
//   Glitch rejection: a bounce shorter than DB_CYCLES produces no event and no state change.
//   Reset mid-debounce discards the partial count.
// CONFIGURATION
//   AUTO_CYCLE_EN defined:
//   - In HEX/BCD/DEC a timer counts up; at AUTO_PERIOD-1 the mode advances HEX->BCD->DEC->HEX and the timer clears.
//   - The timer clears on any press event, on entry to OFF, and on reset.
//   - A press event in the same cycle as the timer terminal count wins over the auto-advance.
//   AUTO_CYCLE_EN undefined: no timer logic; the mode changes only on press events or enable.
// TESTING (bench uses DB_CYCLES=4, AUTO_PERIOD=16)
//   1. Reset, enable=1, SW=4'hC, hold PB=3'b110 for 10 cycles -> mode=1, Hex_7=0001011, Hex_0=4'hC, digit_on=1 within 2+4+2 cycles.
//   2. In HEX, pulse PB=3'b011 for 2 cycles, then 3'b111 -> no event; mode stays 1.
//   3. SW=4'hC, press PB[2] -> mode=3, Hex_7=0100001, Hex_1=1111001, Hex_0=2; then SW=7 -> Hex_1=1111111, Hex_0=7 one cycle later.
//   4. SW=4'hF, press PB[1] -> mode=2, Hex_0=9; then PB=3'b000 held -> PB[0] wins -> mode=1, Hex_0=4'hF.
//   5. In DEC drop enable -> next cycle mode=0, all glyphs 1111111, digit_on=0; enable=1 with no press -> stays OFF; assert rst_n=0 mid-debounce -> all outputs at reset values immediately.
//   6. With AUTO_CYCLE_EN: enter HEX and wait 16 cycles -> BCD; wait 16 more -> DEC; press PB[0] on the terminal cycle -> HEX and the timer restarts.

Source files
------------

// File: rtl/display_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_mode_ctrl: debounced push-button mode FSM driving 7-seg glyphs.   |
// | Optional macro AUTO_CYCLE_EN adds timed HEX->BCD->DEC auto-advance.       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module display_mode_ctrl #(
  parameter int DB_CYCLES   = 500000,
  parameter int DB_W        = 20,
  parameter int AUTO_PERIOD = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] PB,
  input  logic [3:0] SW,
  output logic [1:0] mode,
  output logic [6:0] Hex_7,
  output logic [6:0] Hex_1,
  output logic [3:0] Hex_0,
  output logic       digit_on
);

  typedef enum logic [1:0] {
    OFF = 2'd0,
    HEX = 2'd1,
    BCD = 2'd2,
    DEC = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [6:0]      GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0]      GLYPH_HEX   = 7'b0001011;
  localparam logic [6:0]      GLYPH_BCD   = 7'b0000011;
  localparam logic [6:0]      GLYPH_DEC   = 7'b0100001;
  localparam logic [6:0]      GLYPH_ONE   = 7'b1111001;

  state_t     state;
  state_t     sel;
  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] db_state;
  logic [2:0] db_prev;
  logic [2:0] press;
  logic       press_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= 3'b111;
      sync_b  <= 3'b111;
      db_prev <= 3'b111;
    end else begin
      sync_a  <= PB;
      sync_b  <= sync_a;
      db_prev <= db_state;
    end
  end

  // Each button needs DB_CYCLES consecutive differing samples before it flips.
  generate
    for (genvar i = 0; i < 3; i++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            db_bit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          db_bit <= 1'b1;
        end else if (sync_b[i] == db_bit) begin
          cnt    <= '0;
        end else if (cnt == DB_LAST) begin
          cnt    <= '0;
          db_bit <= sync_b[i];
        end else begin
          cnt    <= cnt + 1'b1;
        end
      end

      assign db_state[i] = db_bit;
    end
  endgenerate

  assign press     = db_prev & ~db_state;
  assign press_any = |press;

  always_comb begin
    sel = OFF;
    if (press[0])      sel = HEX;
    else if (press[1]) sel = BCD;
    else if (press[2]) sel = DEC;
  end

`ifdef AUTO_CYCLE_EN
  localparam int                AUTO_W    = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] timer;
  state_t            auto_next;

  always_comb begin
    auto_next = HEX;
    if (state == HEX)      auto_next = BCD;
    else if (state == BCD) auto_next = DEC;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      Hex_7    <= GLYPH_BLANK;
      Hex_1    <= GLYPH_BLANK;
      Hex_0    <= 4'd0;
      digit_on <= 1'b0;
`ifdef AUTO_CYCLE_EN
      timer    <= '0;
`endif
    end else begin
      if (!enable) begin
        state <= OFF;
`ifdef AUTO_CYCLE_EN
        timer <= '0;
`endif
      end else if (press_any) begin
        state <= sel;
`ifdef AUTO_CYCLE_EN
        timer <= '0;
      end else if (state != OFF) begin
        if (timer == AUTO_LAST) begin
          state <= auto_next;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
`endif
      end

      // Outputs follow the state held this cycle, one cycle behind it.
      Hex_1    <= GLYPH_BLANK;
      Hex_0    <= SW;
      digit_on <= (state != OFF);
      case (state)
        OFF: begin
          Hex_7 <= GLYPH_BLANK;
          Hex_0 <= 4'd0;
        end
        HEX: Hex_7 <= GLYPH_HEX;
        BCD: begin
          Hex_7 <= GLYPH_BCD;
          if (SW > 4'd9) Hex_0 <= 4'd9;
        end
        DEC: begin
          Hex_7 <= GLYPH_DEC;
          if (SW > 4'd9) begin
            Hex_0 <= SW - 4'd10;
            Hex_1 <= GLYPH_ONE;
          end
        end
        default: Hex_7 <= GLYPH_BLANK;
      endcase
    end
  end

  assign mode = state;

endmodule
`default_nettype wire

// File: tb/tb_display_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_display_mode_ctrl: scoreboard bench for display_mode_ctrl.             |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_display_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] PB = 3'b111;
  logic [3:0] SW = 4'd0;
  logic [1:0] mode;
  logic [6:0] Hex_7;
  logic [6:0] Hex_1;
  logic [3:0] Hex_0;
  logic       digit_on;

  display_mode_ctrl #(
    .DB_CYCLES  (4),
    .DB_W       (4),
    .AUTO_PERIOD(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .PB      (PB),
    .SW      (SW),
    .mode    (mode),
    .Hex_7   (Hex_7),
    .Hex_1   (Hex_1),
    .Hex_0   (Hex_0),
    .digit_on(digit_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot layout: {mode[1:0], Hex_7[6:0], Hex_1[6:0], Hex_0[3:0], digit_on}
  logic [20:0] exp_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        armed = 1'b0;
  logic [20:0] snap;
  logic [20:0] last = '0;
  logic [20:0] e_val;
  string       e_name;

  function automatic logic [20:0] mk(input logic [1:0] m, input logic [6:0] h7,
                                     input logic [6:0] h1, input logic [3:0] h0,
                                     input logic on);
    return {m, h7, h1, h0, on};
  endfunction

  function automatic string fmt(input logic [20:0] s);
    return $sformatf("mode=%0d h7=%b h1=%b h0=%h on=%b",
                     s[20:19], s[18:12], s[11:5], s[4:1], s[0]);
  endfunction

  task automatic expect_at(input int dcyc, input logic [20:0] s, input string nm);
    exp_cyc_q.push_back(cyc + dcyc);
    exp_q.push_back(s);
    exp_name_q.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] pb, input int hold);
    PB = pb;
    tick(hold);
    PB = 3'b111;
  endtask

  // Monitor: compares each scheduled expectation on its cycle and flags any
  // output change that nothing was scheduled for.
  always @(negedge clk) begin
    snap = {mode, Hex_7, Hex_1, Hex_0, digit_on};
    if (armed) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        e_name = exp_name_q.pop_front();
        e_val  = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        tests++;
        fails++;
        $display("FAIL %s: missed, now %s, required %s", e_name, fmt(snap), fmt(e_val));
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        e_name = exp_name_q.pop_front();
        e_val  = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        tests++;
        if (snap !== e_val) begin
          fails++;
          $display("FAIL %s @cyc %0d: got %s, required %s", e_name, cyc, fmt(snap), fmt(e_val));
        end
      end else if (snap !== last) begin
        tests++;
        fails++;
        $display("FAIL unexpected_change @cyc %0d: got %s, required %s", cyc, fmt(snap), fmt(last));
      end
    end
    last = snap;
  end

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GH = 7'b0001011;
  localparam logic [6:0] GB = 7'b0000011;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] G1 = 7'b1111001;

  initial begin
    tick(3);
    armed = 1'b1;
    expect_at(1, mk(2'd0, BL, BL, 4'h0, 1'b0), "reset_state");
    tick(1);
    rst_n = 1'b1;

`ifdef AUTO_CYCLE_EN
    enable = 1'b1;
    SW     = 4'h3;
    tick(2);
    expect_at(7,  mk(2'd1, BL, BL, 4'h0, 1'b0), "auto_enter_mode");
    expect_at(8,  mk(2'd1, GH, BL, 4'h3, 1'b1), "auto_enter_hex");
    expect_at(23, mk(2'd2, GH, BL, 4'h3, 1'b1), "auto_bcd_mode");
    expect_at(24, mk(2'd2, GB, BL, 4'h3, 1'b1), "auto_bcd_out");
    expect_at(39, mk(2'd3, GB, BL, 4'h3, 1'b1), "auto_dec_mode");
    expect_at(40, mk(2'd3, GD, BL, 4'h3, 1'b1), "auto_dec_out");
    expect_at(55, mk(2'd1, GD, BL, 4'h3, 1'b1), "auto_press_wins_mode");
    expect_at(56, mk(2'd1, GH, BL, 4'h3, 1'b1), "auto_press_wins_hex");
    expect_at(71, mk(2'd2, GH, BL, 4'h3, 1'b1), "auto_restart_mode");
    expect_at(72, mk(2'd2, GB, BL, 4'h3, 1'b1), "auto_restart_out");
    press(3'b110, 10);
    tick(38);
    press(3'b110, 10);
    tick(16);
    enable = 1'b0;
    expect_at(1, mk(2'd0, GB, BL, 4'h3, 1'b1), "auto_off_mode");
    expect_at(2, mk(2'd0, BL, BL, 4'h0, 1'b0), "auto_off_out");
    tick(4);
`else
    enable = 1'b1;
    SW     = 4'hC;
    tick(2);

    expect_at(7, mk(2'd1, BL, BL, 4'h0, 1'b0), "t1_mode_hex");
    expect_at(8, mk(2'd1, GH, BL, 4'hC, 1'b1), "t1_hex_out");
    press(3'b110, 10);
    tick(20);

    PB = 3'b011;
    tick(2);
    PB = 3'b111;
    expect_at(10, mk(2'd1, GH, BL, 4'hC, 1'b1), "t2_glitch_ignored");
    tick(20);

    expect_at(7, mk(2'd3, GH, BL, 4'hC, 1'b1), "t3_mode_dec");
    expect_at(8, mk(2'd3, GD, G1, 4'h2, 1'b1), "t3_dec_12");
    press(3'b011, 10);
    tick(20);
    SW = 4'h7;
    expect_at(1, mk(2'd3, GD, BL, 4'h7, 1'b1), "t3_dec_7");
    tick(5);

    SW = 4'hF;
    expect_at(1, mk(2'd3, GD, G1, 4'h5, 1'b1), "t4_dec_15");
    tick(5);
    expect_at(7, mk(2'd2, GD, G1, 4'h5, 1'b1), "t4_mode_bcd");
    expect_at(8, mk(2'd2, GB, BL, 4'h9, 1'b1), "t4_bcd_saturate");
    press(3'b101, 10);
    tick(20);
    expect_at(7, mk(2'd1, GB, BL, 4'h9, 1'b1), "t4_priority_mode");
    expect_at(8, mk(2'd1, GH, BL, 4'hF, 1'b1), "t4_priority_hex");
    press(3'b000, 10);
    tick(20);

    expect_at(7, mk(2'd3, GH, BL, 4'hF, 1'b1), "t5_mode_dec");
    expect_at(8, mk(2'd3, GD, G1, 4'h5, 1'b1), "t5_dec_out");
    press(3'b011, 10);
    tick(20);
    enable = 1'b0;
    expect_at(1, mk(2'd0, GD, G1, 4'h5, 1'b1), "t5_disable_mode");
    expect_at(2, mk(2'd0, BL, BL, 4'h0, 1'b0), "t5_disable_out");
    tick(5);
    expect_at(12, mk(2'd0, BL, BL, 4'h0, 1'b0), "t5_press_while_disabled");
    press(3'b110, 10);
    tick(20);
    enable = 1'b1;
    tick(10);
    expect_at(1, mk(2'd0, BL, BL, 4'h0, 1'b0), "t5_enable_stays_off");
    tick(3);
    expect_at(7, mk(2'd3, BL, BL, 4'h0, 1'b0), "t5_reenter_mode");
    expect_at(8, mk(2'd3, GD, G1, 4'h5, 1'b1), "t5_reenter_dec");
    press(3'b011, 10);
    tick(20);

    PB = 3'b110;
    tick(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_at(0, mk(2'd0, BL, BL, 4'h0, 1'b0), "t5_async_reset");
    tick(2);
    rst_n = 1'b1;
    expect_at(7, mk(2'd1, BL, BL, 4'h0, 1'b0), "t5_fresh_debounce_mode");
    expect_at(8, mk(2'd1, GH, BL, 4'hF, 1'b1), "t5_fresh_debounce_hex");
    tick(10);
    PB = 3'b111;
    tick(20);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
